// File: rtl/enable_arbiter_if.sv
// Bundles the two requester ports and the enableblock datapath connection
// of the enable_arbiter.
interface enable_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             enable;
  logic [WIDTH-1:0] a_bus;
  logic [WIDTH-1:0] b_bus;
  logic [WIDTH-1:0] a_ret;
  logic [WIDTH-1:0] b_ret;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] a_res;
  logic [WIDTH-1:0] b_res;

  // The requesters and enableblock side drive requests, operands and returned values.
  modport master (
    output req0, a0, b0, req1, a1, b1, a_ret, b_ret,
    input  enable, a_bus, b_bus, gnt0, gnt1, done0, done1, a_res, b_res
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, a_ret, b_ret,
    output enable, a_bus, b_bus, gnt0, gnt1, done0, done1, a_res, b_res
  );
endinterface

// File: rtl/enable_arbiter.sv
// Two-requester round-robin controller for the enableblock datapath: latches
// the winner's operands, holds enable for HOLD_CYCLES, returns the result.
module enable_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  enable_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t           state, state_next;
  logic             last, last_next;
  logic             owner, owner_next;
  logic [3:0]       cnt, cnt_next;
  logic             enable_q, enable_next;
  logic [WIDTH-1:0] a_bus_q, a_bus_next;
  logic [WIDTH-1:0] b_bus_q, b_bus_next;
  logic             gnt0_q, gnt0_next;
  logic             gnt1_q, gnt1_next;
  logic             done0_q, done0_next;
  logic             done1_q, done1_next;
  logic [WIDTH-1:0] a_res_q, a_res_next;
  logic [WIDTH-1:0] b_res_q, b_res_next;
  logic             pick1;

  // last resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      cnt      <= '0;
      enable_q <= 1'b0;
      a_bus_q  <= '0;
      b_bus_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      a_res_q  <= '0;
      b_res_q  <= '0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      owner    <= owner_next;
      cnt      <= cnt_next;
      enable_q <= enable_next;
      a_bus_q  <= a_bus_next;
      b_bus_q  <= b_bus_next;
      gnt0_q   <= gnt0_next;
      gnt1_q   <= gnt1_next;
      done0_q  <= done0_next;
      done1_q  <= done1_next;
      a_res_q  <= a_res_next;
      b_res_q  <= b_res_next;
    end
  end

  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign pick1 = bus.req1 && (!bus.req0 || (last == 1'b0));

  always_comb begin
    state_next  = state;
    last_next   = last;
    owner_next  = owner;
    cnt_next    = cnt;
    enable_next = enable_q;
    a_bus_next  = a_bus_q;
    b_bus_next  = b_bus_q;
    gnt0_next   = gnt0_q;
    gnt1_next   = gnt1_q;
    done0_next  = 1'b0;
    done1_next  = 1'b0;
    a_res_next  = a_res_q;
    b_res_next  = b_res_q;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_next  = pick1;
          a_bus_next  = pick1 ? bus.a1 : bus.a0;
          b_bus_next  = pick1 ? bus.b1 : bus.b0;
          gnt0_next   = !pick1;
          gnt1_next   = pick1;
          enable_next = 1'b1;
          cnt_next    = HOLD_LOAD;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          a_res_next  = bus.a_ret;
          b_res_next  = bus.b_ret;
          enable_next = 1'b0;
          a_bus_next  = '0;
          b_bus_next  = '0;
          gnt0_next   = 1'b0;
          gnt1_next   = 1'b0;
          done0_next  = !owner;
          done1_next  = owner;
          last_next   = owner;
          state_next  = DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.enable = enable_q;
  assign bus.a_bus  = a_bus_q;
  assign bus.b_bus  = b_bus_q;
  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.a_res  = a_res_q;
  assign bus.b_res  = b_res_q;

endmodule

// File: tb/tb_enable_arbiter.sv
// Drives a HOLD_CYCLES=2 and a HOLD_CYCLES=1 arbiter with identical stimulus and
// checks both against a transaction-level reference model via a scoreboard.
module tb_enable_arbiter;

  localparam int W = 4;

  typedef struct {
    int         winner;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int         start;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  enable_arbiter_if #(.WIDTH(W)) bus2 ();
  enable_arbiter_if #(.WIDTH(W)) bus1 ();

  enable_arbiter #(.WIDTH(W), .HOLD_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  enable_arbiter #(.WIDTH(W), .HOLD_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus2.req0 = req0;
  assign bus2.a0   = a0;
  assign bus2.b0   = b0;
  assign bus2.req1 = req1;
  assign bus2.a1   = a1;
  assign bus2.b1   = b1;
  assign bus1.req0 = req0;
  assign bus1.a0   = a0;
  assign bus1.b0   = b0;
  assign bus1.req1 = req1;
  assign bus1.a1   = a1;
  assign bus1.b1   = b1;

  // Transparent enableblock: passes operands while enable is high.
  assign bus2.a_ret = bus2.enable ? bus2.a_bus : '0;
  assign bus2.b_ret = bus2.enable ? bus2.b_bus : '0;
  assign bus1.a_ret = bus1.enable ? bus1.a_bus : '0;
  assign bus1.b_ret = bus1.enable ? bus1.b_bus : '0;

  logic         en_o [2];
  logic         g0_o [2];
  logic         g1_o [2];
  logic         d0_o [2];
  logic         d1_o [2];
  logic [W-1:0] ab_o [2];
  logic [W-1:0] bb_o [2];
  logic [W-1:0] ar_o [2];
  logic [W-1:0] br_o [2];

  assign en_o[0] = bus2.enable;
  assign en_o[1] = bus1.enable;
  assign g0_o[0] = bus2.gnt0;
  assign g0_o[1] = bus1.gnt0;
  assign g1_o[0] = bus2.gnt1;
  assign g1_o[1] = bus1.gnt1;
  assign d0_o[0] = bus2.done0;
  assign d0_o[1] = bus1.done0;
  assign d1_o[0] = bus2.done1;
  assign d1_o[1] = bus1.done1;
  assign ab_o[0] = bus2.a_bus;
  assign ab_o[1] = bus1.a_bus;
  assign bb_o[0] = bus2.b_bus;
  assign bb_o[1] = bus1.b_bus;
  assign ar_o[0] = bus2.a_res;
  assign ar_o[1] = bus1.a_res;
  assign br_o[0] = bus2.b_res;
  assign br_o[1] = bus1.b_res;

  txn_t         sbq0[$];
  txn_t         sbq1[$];
  int           hold_len [2] = '{2, 1};
  int           last_w [2];
  int           next_free [2];
  int           edge_cnt = 0;
  logic [W-1:0] res_a [2] = '{4'd0, 4'd0};
  logic [W-1:0] res_b [2] = '{4'd0, 4'd0};

  // Reference model: a grant occupies HOLD cycles, a done cycle and an idle
  // cycle, so the next grant may start HOLD+2 edges later.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sbq0.delete();
        sbq1.delete();
        for (int l = 0; l < 2; l++) begin
          last_w[l]    = 1;
          next_free[l] = 0;
        end
      end else begin
        edge_cnt++;
        for (int l = 0; l < 2; l++) begin
          if (edge_cnt >= next_free[l] && (req0 || req1)) begin
            txn_t t;
            if (req0 && req1) t.winner = 1 - last_w[l];
            else              t.winner = req1 ? 1 : 0;
            t.a          = (t.winner == 1) ? a1 : a0;
            t.b          = (t.winner == 1) ? b1 : b0;
            t.start      = edge_cnt;
            last_w[l]    = t.winner;
            next_free[l] = edge_cnt + hold_len[l] + 2;
            if (l == 0) sbq0.push_back(t);
            else        sbq1.push_back(t);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int l, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s (HOLD_CYCLES=%0d, edge %0d): got %h, expected %h",
               name, hold_len[l], edge_cnt, act, exp);
    end
  endtask

  task automatic checkLane(input int l);
    txn_t h;
    logic has;
    logic eg;
    logic ed;
    has = (l == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
    h.winner = 0;
    h.a      = '0;
    h.b      = '0;
    h.start  = 0;
    if (has) begin
      if (l == 0) h = sbq0[0];
      else        h = sbq1[0];
    end
    eg = has && (edge_cnt <= h.start + hold_len[l] - 1);
    ed = has && (edge_cnt == h.start + hold_len[l]);
    if (ed) begin
      res_a[l] = h.a;
      res_b[l] = h.b;
      if (l == 0) void'(sbq0.pop_front());
      else        void'(sbq1.pop_front());
    end
    checkOutput("enable", l, W'(en_o[l]), W'(eg));
    checkOutput("gnt0",   l, W'(g0_o[l]), W'(eg && h.winner == 0));
    checkOutput("gnt1",   l, W'(g1_o[l]), W'(eg && h.winner == 1));
    checkOutput("done0",  l, W'(d0_o[l]), W'(ed && h.winner == 0));
    checkOutput("done1",  l, W'(d1_o[l]), W'(ed && h.winner == 1));
    checkOutput("a_bus",  l, ab_o[l], eg ? h.a : '0);
    checkOutput("b_bus",  l, bb_o[l], eg ? h.b : '0);
    checkOutput("a_res",  l, ar_o[l], res_a[l]);
    checkOutput("b_res",  l, br_o[l], res_b[l]);
    checkOutput("gnt_exclusive", l, W'(g0_o[l] & g1_o[l]), '0);
  endtask

  // Monitor: during reset everything must already be cleared 1 time unit
  // after reset rises; otherwise compare every cycle against the scoreboard.
  initial begin
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        for (int l = 0; l < 2; l++) begin
          res_a[l] = '0;
          res_b[l] = '0;
          checkOutput("rst_enable", l, W'(en_o[l]), '0);
          checkOutput("rst_gnt",    l, W'(g0_o[l] | g1_o[l]), '0);
          checkOutput("rst_done",   l, W'(d0_o[l] | d1_o[l]), '0);
          checkOutput("rst_a_bus",  l, ab_o[l], '0);
          checkOutput("rst_a_res",  l, ar_o[l], '0);
          checkOutput("rst_b_res",  l, br_o[l], '0);
        end
      end else begin
        for (int l = 0; l < 2; l++) checkLane(l);
      end
    end
  end

  task automatic applyStimulus(input logic r0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                               input logic r1, input logic [W-1:0] x1, input logic [W-1:0] y1,
                               input int n);
    req0 = r0;
    a0   = x0;
    b0   = y0;
    req1 = r1;
    a1   = x1;
    b1   = y1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 2);

    // Single request after reset.
    applyStimulus(1, 4'b0101, 4'b1001, 0, 4'h0, 4'h0, 1);
    applyStimulus(0, 4'b0101, 4'b1001, 0, 4'h0, 4'h0, 6);

    // Sustained tie after reset: grants alternate starting with requester 0.
    pulseReset();
    applyStimulus(1, 4'b0011, 4'b1100, 1, 4'b0110, 4'b1101, 24);
    applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 6);

    // Operand change during HOLD.
    applyStimulus(0, 4'h0, 4'h0, 1, 4'b0000, 4'b1111, 1);
    applyStimulus(0, 4'h0, 4'h0, 0, 4'b1000, 4'b1111, 6);

    // Early deassert.
    applyStimulus(1, 4'b0100, 4'b1011, 0, 4'h0, 4'h0, 1);
    applyStimulus(0, 4'h7, 4'h7, 0, 4'h0, 4'h0, 6);

    // Reset in the second HOLD cycle, then both request: requester 0 wins.
    applyStimulus(0, 4'h0, 4'h0, 1, 4'b1010, 4'b0011, 1);
    @(posedge clk);
    #2;
    rst  = 1'b1;
    req0 = 1'b1;
    a0   = 4'b1110;
    b0   = 4'b0001;
    a1   = 4'b0111;
    b1   = 4'b1000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 6);

    // Back-to-back single requester (HOLD_CYCLES=1 lane grants every 3 cycles).
    applyStimulus(0, 4'h0, 4'h0, 1, 4'b1000, 4'b1000, 12);
    applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1);
    end
    applyStimulus(0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
